// File: rtl/grf_wb_scheduler_pkg.sv
// Shared types and constants for the GRF write-port scheduler.
package grf_sched_pkg;

  localparam int REG_AW = 5;
  localparam int DW     = 32;

  // MDU result tracking: nothing in flight, MDU running, result parked waiting for the port
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    HOLD = 2'd2
  } sched_state_e;

  // Which source owns the GRF write port this cycle
  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_WB   = 2'd1,
    SEL_MDU  = 2'd2,
    SEL_HELD = 2'd3
  } port_sel_e;

endpackage

// File: rtl/grf_wb_scheduler_if.sv
// Decode / WB / MDU / GRF-port signal bundle around the write-port scheduler.
// slave  : the scheduler side (consumes requests, drives stalls and the GRF port)
// master : the surrounding pipeline, MDU and GRF
interface grf_wb_scheduler_if;
  import grf_sched_pkg::*;

  logic              id_valid;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic [REG_AW-1:0] id_wa;
  logic              id_mdu;
  logic [DW-1:0]     id_pc;
  logic              id_stall;
  logic              mdu_start;
  logic              mdu_done;
  logic [DW-1:0]     mdu_wd;
  logic              wb_we;
  logic [REG_AW-1:0] wb_wa;
  logic [DW-1:0]     wb_wd;
  logic [DW-1:0]     wb_pc;
  logic              wb_stall;
  logic              grf_we;
  logic [REG_AW-1:0] grf_wa;
  logic [DW-1:0]     grf_wd;
  logic [DW-1:0]     grf_pc;
  logic              proto_err;

  modport slave (
    input  id_valid, id_rs, id_rt, id_wa, id_mdu, id_pc,
    input  mdu_done, mdu_wd,
    input  wb_we, wb_wa, wb_wd, wb_pc,
    output id_stall, mdu_start, wb_stall,
    output grf_we, grf_wa, grf_wd, grf_pc,
    output proto_err
  );

  modport master (
    output id_valid, id_rs, id_rt, id_wa, id_mdu, id_pc,
    output mdu_done, mdu_wd,
    output wb_we, wb_wa, wb_wd, wb_pc,
    input  id_stall, mdu_start, wb_stall,
    input  grf_we, grf_wa, grf_wd, grf_pc,
    input  proto_err
  );

endinterface

// File: rtl/grf_wb_scheduler_scoreboard.sv
// Pending-MDU-result scoreboard: one bit per GRF register, set at MDU issue,
// cleared when the MDU result is written. r0 is never marked pending.
module grf_scoreboard
  import grf_sched_pkg::*;
(
  input  logic              clk,
  input  logic              Reset,
  input  logic              i_set_en,
  input  logic [REG_AW-1:0] i_set_idx,
  input  logic              i_clr_en,
  input  logic [REG_AW-1:0] i_clr_idx,
  input  logic [REG_AW-1:0] i_rs,
  input  logic [REG_AW-1:0] i_rt,
  input  logic [REG_AW-1:0] i_wa,
  output logic              o_pend_rs,
  output logic              o_pend_rt,
  output logic              o_pend_wa
);

  logic [(1<<REG_AW)-1:0] r_sb;

  // Set/clear pending bits; issue and writeback never target the same op in one cycle
  always_ff @(posedge clk) begin
    if (Reset) begin
      r_sb <= '0;
    end else begin
      if (i_clr_en)
        r_sb[i_clr_idx] <= 1'b0;
      if (i_set_en && (i_set_idx != '0))
        r_sb[i_set_idx] <= 1'b1;
    end
  end

  // Lookups with r0 forced clear so it can never create a hazard
  always_comb begin
    o_pend_rs = r_sb[i_rs] & (i_rs != '0);
    o_pend_rt = r_sb[i_rt] & (i_rt != '0);
    o_pend_wa = r_sb[i_wa] & (i_wa != '0);
  end

endmodule

// File: rtl/grf_wb_scheduler.sv
// GRF write-port scheduler: arbitrates the single GRF write port between the
// in-order WB stage and the multi-cycle MDU, stalls decode on hazards against
// pending MDU destinations, and freezes the pipeline when a parked MDU result
// has waited STARVE_MAX cycles.
// Optional: define GRF_SCHED_TRACE_EN to print every non-r0 GRF write.
module grf_wb_scheduler
  import grf_sched_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                Reset,
  grf_wb_scheduler_if.slave   bus
);

  localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  sched_state_e      r_state;
  sched_state_e      w_state_nxt;
  logic [CW-1:0]     r_cnt;
  logic [REG_AW-1:0] r_mdu_wa;
  logic [DW-1:0]     r_mdu_pc;
  logic [DW-1:0]     r_hold_wd;
  logic              r_proto_err;

  logic              w_pend_rs;
  logic              w_pend_rt;
  logic              w_pend_wa;
  logic              w_id_stall;
  logic              w_wb_stall;
  logic              w_accept;
  logic              w_mdu_start;
  logic              w_mdu_direct;
  logic              w_capture;
  logic              w_sb_clr;
  port_sel_e         w_sel;

  grf_scoreboard u_sb (
    .clk       (clk),
    .Reset     (Reset),
    .i_set_en  (w_mdu_start),
    .i_set_idx (bus.id_wa),
    .i_clr_en  (w_sb_clr),
    .i_clr_idx (r_mdu_wa),
    .i_rs      (bus.id_rs),
    .i_rt      (bus.id_rt),
    .i_wa      (bus.id_wa),
    .o_pend_rs (w_pend_rs),
    .o_pend_rt (w_pend_rt),
    .o_pend_wa (w_pend_wa)
  );

  // Hazard detection, issue acceptance and write-port priority
  always_comb begin
    w_wb_stall   = (r_state == HOLD) && (r_cnt == CW'(STARVE_MAX));
    w_id_stall   = bus.id_valid &
                   (w_pend_rs | w_pend_rt | w_pend_wa |
                    (bus.id_mdu & (r_state != IDLE)));
    w_accept     = bus.id_valid & ~w_id_stall & ~w_wb_stall;
    w_mdu_start  = w_accept & bus.id_mdu & ~Reset;
    w_mdu_direct = (r_state == BUSY) & bus.mdu_done & ~bus.wb_we;
    w_capture    = (r_state == BUSY) & bus.mdu_done & bus.wb_we;
    w_sel        = SEL_NONE;
    if (w_wb_stall)
      w_sel = SEL_HELD;
    else if (bus.wb_we)
      w_sel = SEL_WB;
    else if (w_mdu_direct)
      w_sel = SEL_MDU;
    else if (r_state == HOLD)
      w_sel = SEL_HELD;
    // The pending bit drops on the edge that ends the MDU write cycle
    w_sb_clr     = ((w_sel == SEL_MDU) || (w_sel == SEL_HELD)) & ~Reset;
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (Reset)
      r_state <= IDLE;
    else
      r_state <= w_state_nxt;
  end

  // FSM next-state: an MDU result either goes straight to the port or parks in HOLD
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: if (w_mdu_start) w_state_nxt = BUSY;
      BUSY: if (bus.mdu_done) w_state_nxt = bus.wb_we ? HOLD : IDLE;
      HOLD: if (w_wb_stall || !bus.wb_we) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // FSM outputs: drive the GRF port from the selected source; everything quiet in reset
  always_comb begin
    bus.id_stall  = 1'b0;
    bus.mdu_start = 1'b0;
    bus.wb_stall  = 1'b0;
    bus.proto_err = 1'b0;
    bus.grf_we    = 1'b0;
    bus.grf_wa    = '0;
    bus.grf_wd    = '0;
    bus.grf_pc    = '0;
    if (!Reset) begin
      bus.id_stall  = w_id_stall;
      bus.mdu_start = w_mdu_start;
      bus.wb_stall  = w_wb_stall;
      bus.proto_err = r_proto_err;
      unique case (w_sel)
        SEL_WB: begin
          bus.grf_we = 1'b1;
          bus.grf_wa = bus.wb_wa;
          bus.grf_wd = bus.wb_wd;
          bus.grf_pc = bus.wb_pc;
        end
        SEL_MDU: begin
          bus.grf_we = 1'b1;
          bus.grf_wa = r_mdu_wa;
          bus.grf_wd = bus.mdu_wd;
          bus.grf_pc = r_mdu_pc;
        end
        SEL_HELD: begin
          bus.grf_we = 1'b1;
          bus.grf_wa = r_mdu_wa;
          bus.grf_wd = r_hold_wd;
          bus.grf_pc = r_mdu_pc;
        end
        default: ;
      endcase
    end
  end

  // MDU destination/PC latch, parked result, starvation counter and sticky protocol error
  always_ff @(posedge clk) begin
    if (Reset) begin
      r_mdu_wa    <= '0;
      r_mdu_pc    <= '0;
      r_hold_wd   <= '0;
      r_cnt       <= '0;
      r_proto_err <= 1'b0;
    end else begin
      if (w_mdu_start) begin
        r_mdu_wa <= bus.id_wa;
        r_mdu_pc <= bus.id_pc;
      end
      if (w_capture) begin
        r_hold_wd <= bus.mdu_wd;
        r_cnt     <= '0;
      end else if (r_state == HOLD) begin
        if (w_wb_stall)
          r_cnt <= '0;
        else if (bus.wb_we && (r_cnt != CW'(STARVE_MAX)))
          r_cnt <= r_cnt + CW'(1);
      end
      if (bus.mdu_done && (r_state != BUSY))
        r_proto_err <= 1'b1;
    end
  end

`ifdef GRF_SCHED_TRACE_EN
  // Write trace for every architecturally visible GRF update
  always @(posedge clk) begin
    if (bus.grf_we && (bus.grf_wa != '0))
      $display("@%h: $%d <= %h", bus.grf_pc, bus.grf_wa, bus.grf_wd);
  end
`endif

endmodule
